// File: rtl/seq_fixed_multiplier.sv
// Sequential unsigned shift-add fixed-point multiplier: one start/done handshake,
// WIDTH iterations per operation, product truncated by FRAC bits with overflow flag.
module seq_fixed_multiplier #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned FRAC  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] p_out,
  output logic             ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned PW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH:0]     sum;
  logic [PW-1:0]      prod;

  // State and datapath registers; reset has priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, iteration datapath and registered status decode.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    acc_d   = acc_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    sum     = acc_q + (WIDTH + 1)'(q_q[0] ? a_q : '0);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = in_A;
          q_d     = in_B;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_MULT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MULT: begin
        {acc_d, q_d} = {sum, q_q} >> 1;
        cnt_d        = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_MULT);
    done_d = (state_d == S_DONE);
  end

  // Carry bit is provably zero once iterations finish; folding it in keeps it observed.
  assign prod  = {acc_q[WIDTH-1:0], q_q};
  assign p_out = prod[WIDTH+FRAC-1:FRAC];
  assign ovf   = acc_q[WIDTH] | (|prod[PW-1:WIDTH+FRAC]);
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_seq_fixed_multiplier.sv
// Bench for seq_fixed_multiplier: two instances (FRAC=0 and FRAC=3) on shared stimulus,
// checked against hand-computed vectors and an arithmetic product model.
module tb_seq_fixed_multiplier;

  localparam int unsigned W = 10;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy0, done0, ovf0;
  logic [W-1:0] p0;
  logic         busy3, done3, ovf3;
  logic [W-1:0] p3;

  int checks;
  int errors;

  seq_fixed_multiplier #(.WIDTH(W), .FRAC(0)) u_f0 (
    .clk(clk), .rst(rst), .start(start), .in_A(a_in), .in_B(b_in),
    .busy(busy0), .done(done0), .p_out(p0), .ovf(ovf0)
  );

  seq_fixed_multiplier #(.WIDTH(W), .FRAC(3)) u_f3 (
    .clk(clk), .rst(rst), .start(start), .in_A(a_in), .in_B(b_in),
    .busy(busy3), .done(done3), .p_out(p3), .ovf(ovf3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] e0;
    logic         o0;
    logic [W-1:0] e3;
    logic         o3;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: full-precision product, then truncate by frac and test the high part.
  function automatic logic [W-1:0] mdl_p(input int unsigned a, input int unsigned b,
                                         input int unsigned frac);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return W'((p >> frac) % (64'd1 << W));
  endfunction

  function automatic logic mdl_o(input int unsigned a, input int unsigned b,
                                 input int unsigned frac);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return (p >> (W + frac)) != 0;
  endfunction

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done0 !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic check_result(input string nm, input logic [W-1:0] e0, input logic o0,
                              input logic [W-1:0] e3, input logic o3);
    chk({nm, " done_f3"}, 32'(done3), 1);
    chk({nm, " busy_at_done"}, 32'(busy0), 0);
    chk({nm, " p_out_f0"}, 32'(p0), 32'(e0));
    chk({nm, " ovf_f0"}, 32'(ovf0), 32'(o0));
    chk({nm, " p_out_f3"}, 32'(p3), 32'(e3));
    chk({nm, " ovf_f3"}, 32'(ovf3), 32'(o3));
  endtask

  task automatic do_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] e0, input logic o0,
                       input logic [W-1:0] e3, input logic o3);
    int cyc;
    @(negedge clk);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({nm, " busy_after_accept"}, 32'(busy0), 1);
    chk({nm, " done_after_accept"}, 32'(done0), 0);
    wait_done(cyc);
    chk({nm, " latency"}, 32'(cyc), W);
    check_result(nm, e0, o0, e3, o3);
    @(posedge clk);
    #1;
    chk({nm, " done_single_pulse"}, 32'(done0), 0);
    chk({nm, " idle_busy"}, 32'(busy0), 0);
    chk({nm, " p_out_held"}, 32'(p0), 32'(e0));
  endtask

  initial begin
    int cyc;
    int dcount;
    logic [W-1:0] ra, rb;

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    a_in   = '0;
    b_in   = '0;

    vecs[0] = '{a: 10'd25,   b: 10'd40,   e0: 10'd1000, o0: 1'b0, e3: 10'd125, o3: 1'b0};
    vecs[1] = '{a: 10'd100,  b: 10'd20,   e0: 10'd976,  o0: 1'b1, e3: 10'd250, o3: 1'b0};
    vecs[2] = '{a: 10'd1023, b: 10'd1023, e0: 10'd1,    o0: 1'b1, e3: 10'd768, o3: 1'b1};
    vecs[3] = '{a: 10'd0,    b: 10'd1023, e0: 10'd0,    o0: 1'b0, e3: 10'd0,   o3: 1'b0};
    vecs[4] = '{a: 10'd24,   b: 10'd10,   e0: 10'd240,  o0: 1'b0, e3: 10'd30,  o3: 1'b0};
    vecs[5] = '{a: 10'd7,    b: 10'd7,    e0: 10'd49,   o0: 1'b0, e3: 10'd6,   o3: 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy0), 0);
    chk("reset done", 32'(done0), 0);
    chk("reset p_out", 32'(p0), 0);
    chk("reset ovf", 32'(ovf0), 0);
    chk("reset busy_f3", 32'(busy3), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
            vecs[i].e0, vecs[i].o0, vecs[i].e3, vecs[i].o3);
    end

    // Back-to-back: start held high through MULT and DONE.
    @(negedge clk);
    start = 1'b1;
    a_in  = 10'd3;
    b_in  = 10'd5;
    @(posedge clk);
    #1;
    a_in = 10'd6;
    b_in = 10'd7;
    wait_done(cyc);
    chk("b2b first latency", 32'(cyc), W);
    check_result("b2b first", 10'd15, 1'b0, 10'd1, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b rebusy", 32'(busy0), 1);
    chk("b2b done_dropped", 32'(done0), 0);
    wait_done(cyc);
    chk("b2b second latency", 32'(cyc), W);
    check_result("b2b second", 10'd42, 1'b0, 10'd5, 1'b0);
    @(posedge clk);
    #1;
    chk("b2b idle", 32'(busy0), 0);

    // Start pulse during MULT with other operands must be ignored.
    @(negedge clk);
    start = 1'b1;
    a_in  = 10'd9;
    b_in  = 10'd11;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    a_in  = 10'd1;
    b_in  = 10'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc);
    chk("busy_start latency", 32'(cyc), W - 4);
    check_result("busy_start", 10'd99, 1'b0, 10'd12, 1'b0);
    @(posedge clk);
    #1;
    chk("busy_start no_second_done", 32'(done0), 0);

    // Reset after five iterations aborts the operation.
    @(negedge clk);
    start = 1'b1;
    a_in  = 10'd31;
    b_in  = 10'd31;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort busy", 32'(busy0), 0);
    chk("abort done", 32'(done0), 0);
    chk("abort p_out", 32'(p0), 0);
    chk("abort ovf", 32'(ovf0), 0);
    dcount = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      if (done0 === 1'b1 || busy0 === 1'b1) dcount++;
    end
    chk("abort no_activity", 32'(dcount), 0);
    do_op("after_abort", 10'd2, 10'd3, 10'd6, 1'b0, 10'd0, 1'b0);

    // Start and reset at the same edge: reset wins.
    @(negedge clk);
    start = 1'b1;
    rst   = 1'b1;
    a_in  = 10'd5;
    b_in  = 10'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    rst   = 1'b0;
    chk("rst_vs_start busy", 32'(busy0), 0);
    @(posedge clk);
    #1;
    chk("rst_vs_start still_idle", 32'(busy0), 0);

    // Randomized operands against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 8 == 0) rb = W'($urandom_range(0, 3));
      do_op($sformatf("rand%0d %0dx%0d", i, ra, rb), ra, rb,
            mdl_p(ra, rb, 0), mdl_o(ra, rb, 0), mdl_p(ra, rb, 3), mdl_o(ra, rb, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
